// File: rtl/fault_injector_seq.sv
// Purpose: registers SEC-DED codewords and XORs in single, double or adjacent-double faults from a seeded LFSR or fixed positions.
// Latency: 1 cycle from in_valid/in_data to out_valid/out_data/out_mask; inj_count updates on the same edge.
// Backpressure: none; one word per cycle is accepted unconditionally.
module fault_injector_seq #(
  parameter int          WIDTH = 72,
  parameter logic [31:0] SEED  = 32'hACE1_2024,
  parameter int          CNT_W = 32,
  localparam int         PW    = $clog2(WIDTH)
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             in_valid,
  input  logic [WIDTH-1:0] in_data,
  input  logic [2:0]       mode,
  input  logic [15:0]      gap,
  input  logic             oneshot,
  input  logic             fixed_en,
  input  logic [PW-1:0]    fixed_pos0,
  input  logic [PW-1:0]    fixed_pos1,
  output logic             out_valid,
  output logic [WIDTH-1:0] out_data,
  output logic [WIDTH-1:0] out_mask,
  output logic [CNT_W-1:0] inj_count
);

  // An all-zero seed would lock the LFSR, so it is replaced by 1.
  localparam logic [31:0] SEED_EFF = (SEED == 32'd0) ? 32'd1 : SEED;
  localparam logic [31:0] POLY     = 32'h8020_0003;
  localparam logic [31:0] W_FULL   = 32'(WIDTH);
  localparam logic [31:0] W_LO     = 32'(WIDTH / 2);
  localparam logic [31:0] W_HI     = 32'(WIDTH - WIDTH / 2);
  localparam logic [31:0] W_M1     = 32'(WIDTH - 1);

  typedef enum logic [1:0] {
    ST_IDLE  = 2'd0,
    ST_ARMED = 2'd1,
    ST_DONE  = 2'd2
  } state_t;

  state_t           state_q, state_d;
  logic [15:0]      cnt_q, cnt_d;
  logic [31:0]      lfsr_q, lfsr_d;
  logic             out_valid_q, out_valid_d;
  logic [WIDTH-1:0] out_data_q, out_data_d;
  logic [WIDTH-1:0] out_mask_q, out_mask_d;
  logic [CNT_W-1:0] inj_count_q, inj_count_d;

  logic             mode_off;
  logic             inject;
  logic             two_bits;
  logic [31:0]      p0, p1;
  logic [WIDTH-1:0] mask;

  // Scale a 16-bit uniform value into [0, n-1] without a divider.
  function automatic logic [31:0] scale(input logic [15:0] a, input logic [31:0] n);
    logic [47:0] prod;
    prod = {32'd0, a} * {16'd0, n};
    return prod[47:16];
  endfunction

  // Error positions and mask for the word being accepted, from the current LFSR value.
  always_comb begin
    two_bits = 1'b0;
    p0       = 32'd0;
    p1       = 32'd0;
    mask     = '0;
    case (mode)
      3'd1: begin
        p0 = scale(lfsr_q[15:0], W_FULL);
      end
      3'd2: begin
        two_bits = 1'b1;
        p0       = W_LO + scale(lfsr_q[15:0], W_HI);
        p1       = scale(lfsr_q[31:16], W_LO);
      end
      3'd3: begin
        two_bits = lfsr_q[31];
        if (lfsr_q[31]) begin
          p0 = W_LO + scale(lfsr_q[15:0], W_HI);
          p1 = scale(lfsr_q[31:16], W_LO);
        end else begin
          p0 = scale(lfsr_q[15:0], W_FULL);
        end
      end
      3'd4: begin
        two_bits = 1'b1;
        p0       = scale(lfsr_q[15:0], W_M1);
        p1       = p0 + 32'd1;
      end
      default: begin
        two_bits = 1'b0;
      end
    endcase
    // Fixed positions override the LFSR; adjacent mode still pairs p0 with p0+1.
    if (fixed_en) begin
      p0 = 32'(fixed_pos0);
      p1 = (mode == 3'd4) ? 32'(fixed_pos0) + 32'd1 : 32'(fixed_pos1);
    end
    // Out-of-range positions match no bit and so contribute nothing.
    for (int i = 0; i < WIDTH; i++) begin
      mask[i] = (p0 == i[31:0]) || (two_bits && (p1 == i[31:0]));
    end
  end

  // Control FSM, rate counter, LFSR stepping and output register next-state.
  always_comb begin
    state_d     = state_q;
    cnt_d       = cnt_q;
    lfsr_d      = lfsr_q;
    inject      = 1'b0;
    out_valid_d = in_valid;
    out_data_d  = out_data_q;
    out_mask_d  = out_mask_q;
    inj_count_d = inj_count_q;
    mode_off    = (mode == 3'd0) || (mode > 3'd4);

    if (in_valid) begin
      lfsr_d = {1'b0, lfsr_q[31:1]} ^ (lfsr_q[0] ? POLY : 32'd0);
    end

    if (mode_off) begin
      // Off from any state: clear the rate counter and re-arm any oneshot.
      state_d = ST_IDLE;
      cnt_d   = 16'd0;
    end else begin
      // A word arriving while IDLE already sees the new mode.
      if (state_q == ST_IDLE) begin
        state_d = ST_ARMED;
      end
      if ((state_q != ST_DONE) && in_valid) begin
        if (cnt_q >= gap) begin
          inject = 1'b1;
          cnt_d  = 16'd0;
          if (oneshot) begin
            state_d = ST_DONE;
          end
        end else begin
          cnt_d = cnt_q + 16'd1;
        end
      end
    end

    // Data and mask only update for valid words; they hold otherwise.
    if (in_valid) begin
      out_mask_d = inject ? mask : '0;
      out_data_d = in_data ^ out_mask_d;
    end

    if (inject && (inj_count_q != {CNT_W{1'b1}})) begin
      inj_count_d = inj_count_q + 1'b1;
    end
  end

  // State and output registers; reset drops any in-flight word.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q     <= ST_IDLE;
      cnt_q       <= 16'd0;
      lfsr_q      <= SEED_EFF;
      out_valid_q <= 1'b0;
      out_data_q  <= '0;
      out_mask_q  <= '0;
      inj_count_q <= '0;
    end else begin
      state_q     <= state_d;
      cnt_q       <= cnt_d;
      lfsr_q      <= lfsr_d;
      out_valid_q <= out_valid_d;
      out_data_q  <= out_data_d;
      out_mask_q  <= out_mask_d;
      inj_count_q <= inj_count_d;
    end
  end

  assign out_valid = out_valid_q;
  assign out_data  = out_data_q;
  assign out_mask  = out_mask_q;
  assign inj_count = inj_count_q;

endmodule

// File: tb/tb_fault_injector_seq.sv
// Purpose: self-checking bench for fault_injector_seq: directed vector table, reset/stall sequences, randomized model check.
// Latency: expects outputs one clock after each driven word, sampled 1 time unit after the rising edge.
// Backpressure: none; the bench drives at most one word per cycle.
module tb_fault_injector_seq;

  localparam int          W    = 72;
  localparam int          PW   = 7;
  localparam logic [31:0] SEED = 32'hACE1_2024;

  logic          clk = 1'b0;
  logic          rst_n = 1'b0;
  logic          in_valid = 1'b0;
  logic [W-1:0]  in_data = '0;
  logic [2:0]    mode = 3'd0;
  logic [15:0]   gap = 16'd0;
  logic          oneshot = 1'b0;
  logic          fixed_en = 1'b0;
  logic [PW-1:0] fixed_pos0 = '0;
  logic [PW-1:0] fixed_pos1 = '0;
  logic          out_valid;
  logic [W-1:0]  out_data;
  logic [W-1:0]  out_mask;
  logic [31:0]   inj_count;

  fault_injector_seq #(.WIDTH(W), .SEED(SEED), .CNT_W(32)) dut (
    .clk(clk), .rst_n(rst_n), .in_valid(in_valid), .in_data(in_data),
    .mode(mode), .gap(gap), .oneshot(oneshot), .fixed_en(fixed_en),
    .fixed_pos0(fixed_pos0), .fixed_pos1(fixed_pos1),
    .out_valid(out_valid), .out_data(out_data), .out_mask(out_mask),
    .inj_count(inj_count)
  );

  always #5 clk = ~clk;

  int n_vec = 0;
  int n_bad = 0;

  // Reference model state: words seen since the last injection, oneshot spent flag.
  logic [31:0] m_lfsr;
  logic [31:0] m_count;
  int          m_since;
  bit          m_spent;

  typedef struct {
    bit          v;
    logic [2:0]  md;
    logic [15:0] g;
    bit          os;
    bit          fe;
    logic [6:0]  p0;
    logic [6:0]  p1;
    logic [W-1:0] d;
    bit          ev;
    logic [W-1:0] em;
    logic [31:0] ec;
  } vec_t;

  vec_t tbl[$];

  task automatic chk(input string name, input logic [127:0] act, input logic [127:0] exp);
    n_vec++;
    if (act !== exp) begin
      n_bad++;
      $display("FAIL %s: got %h expected %h", name, act, exp);
    end
  endtask

  function automatic logic [W-1:0] bit_at(input int i);
    logic [W-1:0] r;
    r = '0;
    r[i] = 1'b1;
    return r;
  endfunction

  function automatic vec_t mk(input bit v, input int md, input int g, input bit os, input bit fe,
                              input int p0, input int p1, input logic [W-1:0] d,
                              input bit ev, input logic [W-1:0] em, input int ec);
    vec_t r;
    r.v = v;  r.md = 3'(md);  r.g = 16'(g);  r.os = os;  r.fe = fe;
    r.p0 = 7'(p0);  r.p1 = 7'(p1);  r.d = d;  r.ev = ev;  r.em = em;  r.ec = 32'(ec);
    return r;
  endfunction

  function automatic logic [31:0] lfsr_next(input logic [31:0] x);
    return x[0] ? ((x >> 1) ^ 32'h8020_0003) : (x >> 1);
  endfunction

  // Fault mask from the position rules, with plain integer arithmetic.
  function automatic logic [W-1:0] ref_mask(input logic [2:0] md, input logic [31:0] L,
                                           input bit fe, input int f0, input int f1);
    int kind, p0, p1;
    logic [W-1:0] m;
    kind = (md == 3'd1) ? 1 : (md == 3'd2) ? 2 : (md == 3'd3) ? (L[31] ? 2 : 1) : 3;
    p0 = 0;
    p1 = 0;
    if (kind == 1) begin
      p0 = int'(L[15:0]) * W / 65536;
    end else if (kind == 2) begin
      p0 = W / 2 + int'(L[15:0]) * (W - W / 2) / 65536;
      p1 = int'(L[31:16]) * (W / 2) / 65536;
    end else begin
      p0 = int'(L[15:0]) * (W - 1) / 65536;
      p1 = p0 + 1;
    end
    if (fe) begin
      p0 = f0;
      p1 = (kind == 3) ? f0 + 1 : f1;
    end
    m = '0;
    if (p0 < W) m[p0] = 1'b1;
    if (kind != 1 && p1 < W) m[p1] = 1'b1;
    return m;
  endfunction

  task automatic model_init();
    m_lfsr  = SEED;
    m_count = 32'd0;
    m_since = 0;
    m_spent = 1'b0;
  endtask

  task automatic do_reset();
    in_valid = 1'b0;
    rst_n = 1'b0;
    @(posedge clk);
    @(negedge clk);
    rst_n = 1'b1;
    model_init();
  endtask

  // Drive one cycle with the current controls, predict, then check after the edge.
  task automatic cycle(input bit v, input logic [W-1:0] d);
    logic [W-1:0] em;
    bit off, inj;
    in_valid = v;
    in_data  = d;
    off = (mode == 3'd0) || (mode > 3'd4);
    inj = 1'b0;
    if (off) begin
      m_spent = 1'b0;
      m_since = 0;
    end else if (v && !m_spent) begin
      if (m_since >= int'(gap)) begin
        inj = 1'b1;
        m_since = 0;
        if (oneshot) m_spent = 1'b1;
      end else begin
        m_since++;
      end
    end
    em = inj ? ref_mask(mode, m_lfsr, fixed_en, int'(fixed_pos0), int'(fixed_pos1)) : '0;
    if (v) m_lfsr = lfsr_next(m_lfsr);
    if (inj && m_count != 32'hFFFF_FFFF) m_count++;
    @(posedge clk);
    #1;
    chk("out_valid", 128'(out_valid), 128'(v));
    chk("inj_count", 128'(inj_count), 128'(m_count));
    if (v) begin
      chk("out_mask", 128'(out_mask), 128'(em));
      chk("out_data", 128'(out_data), 128'(d ^ em));
    end
  endtask

  function automatic logic [W-1:0] rand_word();
    logic [95:0] r;
    r = {$urandom, $urandom, $urandom};
    return r[W-1:0];
  endfunction

  initial begin
    logic [W-1:0] ff, first_mask, m;
    logic [W-1:0] q1[$];
    logic [W-1:0] q2[$];
    int pc, k;

    ff = 72'hFF;
    // Directed vectors: fixed single, fixed double with gap, oneshot re-arm, boundaries.
    for (int i = 0; i < 4; i++) tbl.push_back(mk(1, 1, 0, 0, 1, 5, 0, '0, 1, bit_at(5), i + 1));
    tbl.push_back(mk(0, 0, 0, 0, 1, 5, 0, '0, 0, '0, 4));
    for (int i = 1; i <= 9; i++)
      tbl.push_back(mk(1, 2, 2, 0, 1, 70, 3, ff, 1,
                       (i % 3 == 0) ? (bit_at(70) | bit_at(3)) : '0, 4 + i / 3));
    tbl.push_back(mk(0, 0, 0, 0, 1, 5, 0, '0, 0, '0, 7));
    for (int i = 0; i < 10; i++) tbl.push_back(mk(1, 1, 0, 1, 1, 5, 0, '0, 1, (i == 0) ? bit_at(5) : '0, 8));
    tbl.push_back(mk(0, 0, 0, 1, 1, 5, 0, '0, 0, '0, 8));
    tbl.push_back(mk(1, 1, 0, 1, 1, 5, 0, '0, 1, bit_at(5), 9));
    tbl.push_back(mk(1, 0, 0, 1, 1, 5, 0, ff, 1, '0, 9));
    tbl.push_back(mk(1, 4, 0, 0, 1, 10, 0, '0, 1, bit_at(10) | bit_at(11), 10));
    tbl.push_back(mk(1, 4, 0, 0, 1, 71, 0, '0, 1, bit_at(71), 11));
    tbl.push_back(mk(1, 2, 0, 0, 1, 9, 9, ff, 1, bit_at(9), 12));
    tbl.push_back(mk(1, 2, 0, 0, 1, 9, 100, ff, 1, bit_at(9), 13));
    tbl.push_back(mk(1, 5, 0, 0, 1, 9, 9, ff, 1, '0, 13));
    tbl.push_back(mk(0, 1, 0, 0, 1, 9, 9, ff, 0, '0, 13));

    #2;
    chk("reset_out_valid", 128'(out_valid), 128'(0));
    chk("reset_inj_count", 128'(inj_count), 128'(0));
    chk("reset_out_mask", 128'(out_mask), 128'(0));
    do_reset();

    for (int i = 0; i < tbl.size(); i++) begin
      in_valid = tbl[i].v;   mode = tbl[i].md;   gap = tbl[i].g;   oneshot = tbl[i].os;
      fixed_en = tbl[i].fe;  fixed_pos0 = tbl[i].p0;  fixed_pos1 = tbl[i].p1;  in_data = tbl[i].d;
      @(posedge clk);
      #1;
      chk($sformatf("tbl%0d_valid", i), 128'(out_valid), 128'(tbl[i].ev));
      chk($sformatf("tbl%0d_count", i), 128'(inj_count), 128'(tbl[i].ec));
      if (tbl[i].ev) begin
        chk($sformatf("tbl%0d_mask", i), 128'(out_mask), 128'(tbl[i].em));
        chk($sformatf("tbl%0d_data", i), 128'(out_data), 128'(tbl[i].d ^ tbl[i].em));
      end
    end

    // Mid-stream reset, then the LFSR sequence must restart identically.
    mode = 3'd1; gap = 16'd0; oneshot = 1'b0; fixed_en = 1'b0;
    do_reset();
    cycle(1'b1, rand_word());
    first_mask = out_mask;
    for (int i = 0; i < 5; i++) cycle(1'b1, rand_word());
    in_valid = 1'b1;
    in_data  = rand_word();
    #2;
    rst_n = 1'b0;
    #1;
    chk("midreset_out_valid", 128'(out_valid), 128'(0));
    chk("midreset_out_data", 128'(out_data), 128'(0));
    chk("midreset_out_mask", 128'(out_mask), 128'(0));
    chk("midreset_inj_count", 128'(inj_count), 128'(0));
    @(posedge clk);
    @(negedge clk);
    rst_n = 1'b1;
    model_init();
    cycle(1'b1, rand_word());
    chk("reset_repeat_first_mask", 128'(out_mask), 128'(first_mask));

    // Stalls: masks for valid words must match the unstalled run.
    mode = 3'd2; gap = 16'd1; oneshot = 1'b0; fixed_en = 1'b0;
    do_reset();
    for (int i = 0; i < 8; i++) begin
      cycle(1'b1, rand_word());
      q1.push_back(out_mask);
    end
    do_reset();
    for (int i = 0; i < 8; i++) begin
      cycle(1'b1, rand_word());
      q2.push_back(out_mask);
      cycle(1'b0, rand_word());
    end
    for (int i = 0; i < 8; i++) chk($sformatf("stall_mask%0d", i), 128'(q2[i]), 128'(q1[i]));

    // Random LFSR modes with structural property checks on every injected mask.
    do_reset();
    for (int s = 0; s < 3; s++) begin
      mode = (s == 0) ? 3'd2 : (s == 1) ? 3'd3 : 3'd4;
      for (int i = 0; i < 2000; i++) begin
        bit v;
        if (i % 100 == 0) gap = 16'($urandom_range(0, 2));
        v = ($urandom_range(0, 9) < 8);
        cycle(v, rand_word());
        if (v) begin
          chk("xor_equals_mask", 128'(out_data ^ in_data), 128'(out_mask));
          m = out_mask;
          if (m != '0) begin
            pc = $countones(m);
            chk("popcount_1_or_2", 128'(pc == 1 || pc == 2), 128'(1));
            if (mode == 3'd2) begin
              chk("double_hi_half", 128'($countones(m[W-1:W/2])), 128'(1));
              chk("double_lo_half", 128'($countones(m[W/2-1:0])), 128'(1));
            end
            if (mode == 3'd4) begin
              k = 0;
              while (k < W && !m[k]) k++;
              chk("adjacent_k_range", 128'(k <= W - 2), 128'(1));
              chk("adjacent_pair", 128'(m), 128'(bit_at(k) | bit_at(k + 1)));
            end
          end
        end
      end
    end

    // Fully mixed controls, including off modes, oneshot and fixed positions.
    for (int i = 0; i < 1500; i++) begin
      if ($urandom_range(0, 19) == 0) mode = 3'($urandom_range(0, 7));
      if ($urandom_range(0, 19) == 0) gap = 16'($urandom_range(0, 3));
      if ($urandom_range(0, 19) == 0) oneshot = 1'($urandom_range(0, 1));
      if ($urandom_range(0, 19) == 0) fixed_en = 1'($urandom_range(0, 1));
      fixed_pos0 = 7'($urandom_range(0, 127));
      fixed_pos1 = 7'($urandom_range(0, 127));
      cycle(($urandom_range(0, 3) != 0), rand_word());
    end

    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_bad);
    $finish;
  end

endmodule

// File: doc/fault_injector_seq.md
# fault_injector_seq

Clocked, parametrised fault injector for SEC-DED codeword paths of arbitrary width. It sits between an ECC encoder (or storage array read port) and the decoder under test. Each valid codeword is registered and, according to mode, rate and arming controls, XORed with a single-bit, double-bit or adjacent-double-bit error mask. Error positions come from a synthesizable seeded LFSR or from fixed positions supplied by the bench. It replaces the combinational `$urandom` injector, so the same block works in simulation and on FPGA and reproduces identical fault sequences from a seed.

## Interface
- WIDTH, 72: codeword width in bits (>= 4).
- SEED, 32'hACE1_2024: LFSR reset value; 0 is replaced by 1.
- CNT_W, 32: width of the injection counter.
- PW: derived, $clog2(WIDTH); width of the position inputs.

- clk  in  1  clock; all state updates on rising edge.
- rst_n  in  1  asynchronous, active-low reset.
- in_valid  in  1  in_data carries a codeword this cycle.
- in_data  in  WIDTH  codeword to corrupt.
- mode  in  3  000 off, 001 single, 010 double, 011 random single/double, 100 adjacent double; 101-111 treated as off.
- gap  in  16  number of clean words between injections.
- oneshot  in  1  inject once, then stop until re-armed.
- fixed_en  in  1  use fixed_pos0/1 instead of LFSR positions.
- fixed_pos0  in  PW  first fixed position.
- fixed_pos1  in  PW  second fixed position.
- out_valid  out  1  registered in_valid.
- out_data  out  WIDTH  in_data ^ mask, registered.
- out_mask  out  WIDTH  mask applied to this word; 0 when not injected.
- inj_count  out  CNT_W  number of words injected; saturating.

## Operation
- Control FSM has three states:
  - IDLE: entered when mode is off, and held while mode is off.
  - ARMED: entered from IDLE when mode is not off.
  - DONE: entered from ARMED after an injection when oneshot=1. Leaves DONE only when mode becomes off, which returns it to IDLE.
- Rate counter cnt (16 bit):
  - Cleared while in IDLE.
  - On each accepted word (in_valid=1) in ARMED: if cnt >= gap, inject and set cnt<=0; otherwise cnt<=cnt+1.
  - Result: words number gap+1, 2(gap+1), ... are corrupted. gap=0 corrupts every word.
- LFSR: 32-bit Galois, polynomial x^32+x^22+x^2+x+1 (mask 32'h8020_0003). It advances once per in_valid cycle in every state, and holds when in_valid=0. Current value L is used for the word being accepted.
- Random positions, using r(a,n) = (a*n)>>16 with 16-bit a, which gives a result in [0,n-1]:
  - single: p0 = r(L[15:0], WIDTH).
  - double: p0 = WIDTH/2 + r(L[15:0], WIDTH-WIDTH/2) and p1 = r(L[31:16], WIDTH/2). The two bits are always distinct.
  - random: L[31]=0 selects single, L[31]=1 selects double.
  - adjacent: p0 = r(L[15:0], WIDTH-1) and p1 = p0+1.
- fixed_en=1 overrides p0/p1 with fixed_pos0/1. In random mode, L[31] still chooses single or double.
- Mask construction:
  - Mask is the OR of one-hot(p0) and, for double modes, one-hot(p1).
  - Equal positions yield a single bit.
  - A position >= WIDTH contributes nothing.
  - In adjacent mode with fixed_en=1, p1 = fixed_pos0+1, and that bit is dropped if it falls outside the word.
- inj_count increments by 1 per injected word, not per bit, and saturates at all-ones.

## Timing
- Latency is 1 cycle: a word accepted at edge N appears on out_* after edge N.
- No backpressure; one word per cycle is accepted.
- out_valid=0 cycles:
  - out_data and out_mask hold their last values.
  - Bench must ignore them.
- Reset (async assert, sync release):
  - Outputs: out_valid=0, out_data=0, out_mask=0, inj_count=0.
  - State: FSM=IDLE, cnt=0, LFSR=SEED.
  - Reset mid-stream discards the in-flight word.
- Mode change takes effect on the next accepted word. Changing between non-off modes does not clear cnt. Going to off clears cnt and re-arms a oneshot.
- If in_valid=1 and a DONE->IDLE transition occur in the same cycle, the word passes clean.

## Test plan
1. Reset: drive 10 words in mode 001 with gap=0, assert rst_n=0 mid-stream -> all outputs 0 immediately, inj_count=0. After release, the first LFSR-derived mask equals the mask from the first run.
2. Fixed single: mode=001, fixed_en=1, fixed_pos0=5, gap=0, in_data=0 for 4 words -> each out_data=out_mask=1<<5 one cycle later, inj_count=4.
3. Fixed double with rate: mode=010, fixed_pos0=70, fixed_pos1=3, gap=2, 9 words of 72'hFF -> words 3, 6 and 9 have bits 70 and 3 flipped, all others clean, inj_count=3.
4. Oneshot re-arm: mode=001, oneshot=1, gap=0, 10 words -> only word 1 corrupted, inj_count=1. Then mode=000 for 1 cycle and back to 001 -> the next word is corrupted, inj_count=2.
5. Random modes: fixed_en=0, 2000 words each in modes 010, 011 and 100 ->
   - Every mask popcount is 1 or 2.
   - Double masks have one bit in [36,71] and one in [0,35].
   - Adjacent masks are bits k and k+1 with k <= 70.
   - out_data ^ in_data == out_mask.
6. Stalls: alternate in_valid 1/0 with gap=1 -> out_valid mirrors in_valid delayed by 1. cnt and LFSR hold on idle cycles, so the mask sequence matches the unstalled run.
